cacheline_adapter: RTL and testbench

CACHELINE_ADAPTER -- requirements
Module: cacheline_adapter

---
 rtl/cache_types_pkg.sv | 31 +++
 rtl/cacheline_adapter.sv | 155 +++++++++++++++
 tb/tb_cacheline_adapter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_types_pkg.sv
// Shared types and geometry for the cache-line to memory-burst adapter.
package cache_types_pkg;

    localparam int unsigned LINE_W   = 256;
    localparam int unsigned BEAT_W   = 64;
    localparam int unsigned BEATS    = 4;
    localparam int unsigned OFFSET_W = 5;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned CNT_W    = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_e;

    // Select beat idx (slot k = bits 64k+63:64k) of a full line.
    function automatic logic [BEAT_W-1:0] beat_sel(input logic [LINE_W-1:0] line,
                                                   input logic [CNT_W-1:0]  idx);
        logic [BEAT_W-1:0] beat;
        case (idx)
            2'd0:    beat = line[0*BEAT_W +: BEAT_W];
            2'd1:    beat = line[1*BEAT_W +: BEAT_W];
            2'd2:    beat = line[2*BEAT_W +: BEAT_W];
            default: beat = line[3*BEAT_W +: BEAT_W];
        endcase
        return beat;
    endfunction

endpackage

// File: rtl/cacheline_adapter.sv
// Bridges 256-bit cache line fills/write-backs to 4-beat 64-bit memory bursts.
module cacheline_adapter
    import cache_types_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [LINE_W-1:0]   line_i,
    output logic [LINE_W-1:0]   line_o,
    input  logic [ADDR_W-1:0]   address_i,
    input  logic                read_i,
    input  logic                write_i,
    output logic                resp_o,
    input  logic [BEAT_W-1:0]   burst_i,
    output logic [BEAT_W-1:0]   burst_o,
    output logic [ADDR_W-1:0]   address_o,
    output logic                read_o,
    output logic                write_o,
    input  logic                resp_i
);

    localparam int unsigned BUF_W = BEAT_W * (BEATS - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]   wline_q, wline_d;
    logic [BUF_W-1:0]    rbuf_q, rbuf_d;
    logic [LINE_W-1:0]   line_q, line_d;

    logic                read_d, write_d, resp_d;
    logic [ADDR_W-1:0]   address_d;
    logic [BEAT_W-1:0]   burst_d;
    logic                read_q, write_q, resp_q;
    logic [ADDR_W-1:0]   address_q;
    logic [BEAT_W-1:0]   burst_q;

    // State register: FSM state, beat counter, latched request and line buffers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            rbuf_q  <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            rbuf_q  <= rbuf_d;
            line_q  <= line_d;
        end
    end

    // Next-state: request capture, beat counting and read-line assembly.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wline_d = wline_q;
        rbuf_d  = rbuf_q;
        line_d  = line_q;
        case (state_q)
            IDLE: begin
                if (write_i) begin
                    addr_d  = address_i;
                    wline_d = line_i;
                    cnt_d   = '0;
                    state_d = WR;
                end else if (read_i) begin
                    addr_d  = address_i;
                    cnt_d   = '0;
                    state_d = RD;
                end
            end
            RD: begin
                if (resp_i) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    case (cnt_q)
                        2'd0:    rbuf_d[0*BEAT_W +: BEAT_W] = burst_i;
                        2'd1:    rbuf_d[1*BEAT_W +: BEAT_W] = burst_i;
                        2'd2:    rbuf_d[2*BEAT_W +: BEAT_W] = burst_i;
                        default: begin
                            // Last beat goes straight into the visible line.
                            line_d  = {burst_i, rbuf_q};
                            state_d = DONE;
                        end
                    endcase
                end
            end
            WR: begin
                if (resp_i) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(BEATS - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from next state so every output is registered with the state.
    always_comb begin
        read_d    = 1'b0;
        write_d   = 1'b0;
        resp_d    = 1'b0;
        address_d = '0;
        burst_d   = '0;
        case (state_d)
            RD: begin
                read_d    = 1'b1;
                address_d = {addr_d[ADDR_W-1:OFFSET_W], OFFSET_W'(0)};
            end
            WR: begin
                write_d   = 1'b1;
                address_d = {addr_d[ADDR_W-1:OFFSET_W], OFFSET_W'(0)};
                burst_d   = beat_sel(wline_d, cnt_d);
            end
            DONE: begin
                resp_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            resp_q    <= 1'b0;
            address_q <= '0;
            burst_q   <= '0;
        end else begin
            read_q    <= read_d;
            write_q   <= write_d;
            resp_q    <= resp_d;
            address_q <= address_d;
            burst_q   <= burst_d;
        end
    end

    assign read_o    = read_q;
    assign write_o   = write_q;
    assign resp_o    = resp_q;
    assign address_o = address_q;
    assign burst_o   = burst_q;
    assign line_o    = line_q;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed self-checking bench for cacheline_adapter.
module tb_cacheline_adapter;

    logic         clk;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    int total = 0;
    int bad   = 0;
    logic [255:0] cur_line = '0;

    cacheline_adapter dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] bt(input logic [255:0] line, input int i);
        return line[i*64 +: 64];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Line-fill request; pat bit k gives resp_i for the k-th burst cycle (then 1s).
    task automatic rd_burst(input logic [31:0] addr, input logic [255:0] beats,
                            input logic [15:0] pat, input bit hold, input int exp_lat);
        int k, bi, cyc;
        address_i = addr;
        read_i    = 1'b1;
        write_i   = 1'b0;
        tick();
        cyc = 1;
        chk("rd_req_read_o", 256'(read_o), 256'(1'b1));
        chk("rd_req_write_o", 256'(write_o), 256'(1'b0));
        chk("rd_addr", 256'(address_o), 256'({addr[31:5], 5'b0}));
        address_i = 32'hFFFF_FFFF;
        bi = 0;
        k  = 0;
        while (bi < 4 && cyc < 40) begin
            resp_i  = (k < 16) ? pat[k] : 1'b1;
            burst_i = resp_i ? bt(beats, bi) : 64'hDEAD_BEEF_0BAD_F00D;
            tick();
            cyc++;
            if (resp_i) bi++;
            k++;
            if (bi < 4) begin
                chk("rd_mid_read_o", 256'(read_o), 256'(1'b1));
                chk("rd_mid_resp_o", 256'(resp_o), 256'(1'b0));
                chk("rd_mid_line_hold", line_o, cur_line);
            end
        end
        chk("rd_beats_taken", 256'(bi), 256'(4));
        chk("rd_done_resp_o", 256'(resp_o), 256'(1'b1));
        chk("rd_done_read_o", 256'(read_o), 256'(1'b0));
        chk("rd_done_addr", 256'(address_o), 256'(0));
        chk("rd_line", line_o, beats);
        chk("rd_latency", 256'(cyc + 1), 256'(exp_lat));
        cur_line  = beats;
        resp_i    = 1'b0;
        burst_i   = '0;
        address_i = addr;
        read_i    = hold;
        tick();
        chk("rd_post_resp_o", 256'(resp_o), 256'(1'b0));
        chk("rd_post_read_o", 256'(read_o), 256'(1'b0));
    endtask

    // Write-back request; both=1 also raises read_i to exercise priority.
    task automatic wr_burst(input logic [31:0] addr, input logic [255:0] line,
                            input logic [15:0] pat, input bit both);
        int k, bi, cyc, wcnt;
        address_i = addr;
        line_i    = line;
        write_i   = 1'b1;
        read_i    = both;
        tick();
        cyc  = 1;
        wcnt = 1;
        chk("wr_req_write_o", 256'(write_o), 256'(1'b1));
        chk("wr_req_read_o", 256'(read_o), 256'(1'b0));
        chk("wr_addr", 256'(address_o), 256'({addr[31:5], 5'b0}));
        chk("wr_beat0", 256'(burst_o), 256'(bt(line, 0)));
        address_i = 32'h0;
        line_i    = ~line;
        bi = 0;
        k  = 0;
        while (bi < 4 && cyc < 40) begin
            resp_i = (k < 16) ? pat[k] : 1'b1;
            tick();
            cyc++;
            if (resp_i) bi++;
            k++;
            if (bi < 4) begin
                wcnt++;
                chk("wr_mid_write_o", 256'(write_o), 256'(1'b1));
                chk("wr_mid_read_o", 256'(read_o), 256'(1'b0));
                chk("wr_mid_resp_o", 256'(resp_o), 256'(1'b0));
                chk("wr_beat", 256'(burst_o), 256'(bt(line, bi)));
            end
        end
        chk("wr_beats_taken", 256'(bi), 256'(4));
        chk("wr_done_resp_o", 256'(resp_o), 256'(1'b1));
        chk("wr_done_write_o", 256'(write_o), 256'(1'b0));
        chk("wr_done_read_o", 256'(read_o), 256'(1'b0));
        chk("wr_line_o_kept", line_o, cur_line);
        if (pat == 16'hFFFF) chk("wr_write_cycles", 256'(wcnt), 256'(4));
        resp_i  = 1'b0;
        write_i = 1'b0;
        read_i  = 1'b0;
        tick();
        chk("wr_post_resp_o", 256'(resp_o), 256'(1'b0));
        chk("wr_post_write_o", 256'(write_o), 256'(1'b0));
    endtask

    logic [255:0] l_rd1, l_wr, l_rd2, l_rd3, l_rd4, l_rd5;

    initial begin
        l_rd1 = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        l_wr  = {64'hD0D1_D2D3_D4D5_D6D7, 64'hC0C1_C2C3_C4C5_C6C7,
                 64'hB0B1_B2B3_B4B5_B6B7, 64'hA0A1_A2A3_A4A5_A6A7};
        l_rd2 = {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
                 64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101};
        l_rd3 = {64'h5555_0000_0000_0004, 64'h5555_0000_0000_0003,
                 64'h5555_0000_0000_0002, 64'h5555_0000_0000_0001};
        l_rd4 = {64'h6666_0000_0000_0004, 64'h6666_0000_0000_0003,
                 64'h6666_0000_0000_0002, 64'h6666_0000_0000_0001};
        l_rd5 = {64'h7777_0000_0000_0004, 64'h7777_0000_0000_0003,
                 64'h7777_0000_0000_0002, 64'h7777_0000_0000_0001};

        rst       = 1'b1;
        line_i    = '0;
        address_i = '0;
        read_i    = 1'b0;
        write_i   = 1'b0;
        burst_i   = '0;
        resp_i    = 1'b0;
        #12;
        chk("rst_read_o", 256'(read_o), 256'(1'b0));
        chk("rst_write_o", 256'(write_o), 256'(1'b0));
        chk("rst_resp_o", 256'(resp_o), 256'(1'b0));
        chk("rst_addr", 256'(address_o), 256'(0));
        chk("rst_burst_o", 256'(burst_o), 256'(0));
        chk("rst_line_o", line_o, 256'(0));
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Stray memory acknowledges while idle do nothing.
        resp_i = 1'b1;
        tick();
        tick();
        chk("idle_resp_read_o", 256'(read_o), 256'(1'b0));
        chk("idle_resp_write_o", 256'(write_o), 256'(1'b0));
        chk("idle_resp_resp_o", 256'(resp_o), 256'(1'b0));
        resp_i = 1'b0;
        tick();

        // Basic read, back-to-back beats: 6 cycles request to resp_o inclusive.
        rd_burst(32'h0000_1234, l_rd1, 16'hFFFF, 1'b0, 6);

        // Basic write-back; line_o must keep the last read line.
        wr_burst(32'h8000_00FF, l_wr, 16'hFFFF, 1'b0);

        // Stalled read: resp_i = 1,0,0,1,0,1,1.
        rd_burst(32'h0000_2000, l_rd2, 16'h0069, 1'b0, 9);

        // Read and write together: write wins, with a stall in the burst.
        wr_burst(32'h1234_5678, ~l_wr, 16'hFFFB, 1'b1);

        // Reset mid-read after two beats.
        address_i = 32'h0000_0100;
        read_i    = 1'b1;
        tick();
        resp_i  = 1'b1;
        burst_i = 64'hBAD0_BAD0_BAD0_0001;
        tick();
        burst_i = 64'hBAD0_BAD0_BAD0_0002;
        tick();
        resp_i = 1'b0;
        chk("pre_rst_read_o", 256'(read_o), 256'(1'b1));
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_read_o", 256'(read_o), 256'(1'b0));
        chk("async_rst_addr", 256'(address_o), 256'(0));
        chk("async_rst_line_o", line_o, 256'(0));
        read_i = 1'b0;
        tick();
        chk("rst_no_resp_o", 256'(resp_o), 256'(1'b0));
        @(negedge clk);
        rst = 1'b0;
        cur_line = '0;
        tick();
        chk("post_rst_resp_o", 256'(resp_o), 256'(1'b0));
        rd_burst(32'h0000_0040, l_rd3, 16'hFFFF, 1'b0, 6);

        // Held request: read_i stays high one cycle past resp_o.
        rd_burst(32'h0000_3000, l_rd4, 16'hFFFF, 1'b1, 6);
        rd_burst(32'h0000_3000, l_rd5, 16'hFFFF, 1'b0, 6);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Read and write requests to memory must never overlap.
    always @(negedge clk) begin
        if (read_o && write_o) begin
            total++;
            bad++;
            $display("FAIL rd_wr_overlap got=1 exp=0");
        end
    end

endmodule
